// File: rtl/vblank_task_scheduler.sv
// rtl/vblank_task_scheduler.sv - per-frame vblank sequencer granting update engines over req/ack
module vblank_task_scheduler #(
    parameter int N_TASKS     = 4,
    parameter int TASK_W      = 2,
    parameter int ACTIVE_V    = 480,
    parameter int TIMEOUT_CYC = 4096
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               enable,
    input  logic [9:0]         hPos,
    input  logic [9:0]         vPos,
    input  logic               pause,
    input  logic [N_TASKS-1:0] task_en,
    input  logic [N_TASKS-1:0] task_ack,
    output logic [N_TASKS-1:0] task_req,
    output logic [TASK_W-1:0]  task_id,
    output logic               busy,
    output logic               in_vblank,
    output logic               frame_start,
    output logic [15:0]        frame_count,
    output logic [N_TASKS-1:0] timeout_err,
    output logic               overrun,
    output logic [7:0]         overrun_cnt
);

    // idx must be able to hold N_TASKS itself, the "all tasks visited" marker
    localparam int IDX_W = $clog2(N_TASKS + 1);

    typedef enum logic [1:0] {S_IDLE, S_SEL, S_REQ, S_GAP} state_t;

    state_t             state_q, state_d;
    logic [IDX_W-1:0]   idx_q, idx_d;
    logic [N_TASKS-1:0] mask_q, mask_d;
    logic [15:0]        timer_q, timer_d;
    logic [N_TASKS-1:0] req_q, req_d;
    logic [TASK_W-1:0]  id_q, id_d;
    logic [N_TASKS-1:0] terr_q, terr_d;
    logic               over_q, over_d;
    logic [7:0]         ocnt_q, ocnt_d;
    logic               vblank_q;
    logic               fs_q;
    logic [15:0]        fcnt_q;

    logic               vblank_now;
    logic               fs_hit;
    logic               vblank_fall;
    logic [N_TASKS-1:0] cur_bit;

    assign vblank_now  = (vPos >= 10'(ACTIVE_V));
    assign fs_hit      = enable && (hPos == 10'd0) && (vPos == 10'(ACTIVE_V));
    assign vblank_fall = vblank_q && !vblank_now;
    assign cur_bit     = N_TASKS'(1) << idx_q;

    // Frame timing: vblank flag, frame_start pulse and frame counter
    always_ff @(posedge clk) begin
        if (!reset) begin
            vblank_q <= 1'b0;
            fs_q     <= 1'b0;
            fcnt_q   <= 16'd0;
        end else begin
            vblank_q <= vblank_now;
            fs_q     <= fs_hit;
            if (fs_hit) begin
                fcnt_q <= fcnt_q + 16'd1;
            end
        end
    end

    // Scheduler state register
    always_ff @(posedge clk) begin
        if (!reset) begin
            state_q <= S_IDLE;
            idx_q   <= '0;
            mask_q  <= '0;
            timer_q <= 16'd0;
            req_q   <= '0;
            id_q    <= '0;
            terr_q  <= '0;
            over_q  <= 1'b0;
            ocnt_q  <= 8'd0;
        end else begin
            state_q <= state_d;
            idx_q   <= idx_d;
            mask_q  <= mask_d;
            timer_q <= timer_d;
            req_q   <= req_d;
            id_q    <= id_d;
            terr_q  <= terr_d;
            over_q  <= over_d;
            ocnt_q  <= ocnt_d;
        end
    end

    // Next-state logic; losing vblank while busy preempts every state
    always_comb begin
        state_d = state_q;
        idx_d   = idx_q;
        mask_d  = mask_q;
        timer_d = timer_q;
        req_d   = req_q;
        id_d    = id_q;
        terr_d  = terr_q;
        over_d  = 1'b0;
        ocnt_d  = ocnt_q;
        if (vblank_fall && (state_q != S_IDLE)) begin
            state_d = S_IDLE;
            req_d   = '0;
            over_d  = 1'b1;
            if (ocnt_q != 8'hFF) begin
                ocnt_d = ocnt_q + 8'd1;
            end
        end else begin
            case (state_q)
                S_IDLE: begin
                    if (fs_q && !pause) begin
                        mask_d  = task_en;
                        idx_d   = '0;
                        state_d = S_SEL;
                    end
                end
                S_SEL: begin
                    if (idx_q == IDX_W'(N_TASKS)) begin
                        state_d = S_IDLE;
                    end else if ((mask_q & cur_bit) == '0) begin
                        idx_d = idx_q + IDX_W'(1);
                    end else begin
                        req_d   = cur_bit;
                        id_d    = TASK_W'(idx_q);
                        timer_d = 16'd0;
                        state_d = S_REQ;
                    end
                end
                S_REQ: begin
                    // ack is checked first so a simultaneous expiry is not an error
                    if ((task_ack & req_q) != '0) begin
                        req_d   = '0;
                        idx_d   = idx_q + IDX_W'(1);
                        state_d = S_GAP;
                    end else if (timer_q == 16'(TIMEOUT_CYC - 1)) begin
                        req_d   = '0;
                        terr_d  = terr_q | req_q;
                        idx_d   = idx_q + IDX_W'(1);
                        state_d = S_GAP;
                    end else begin
                        timer_d = timer_q + 16'd1;
                    end
                end
                S_GAP: begin
                    state_d = S_SEL;
                end
                default: begin
                    state_d = S_IDLE;
                end
            endcase
        end
    end

    assign task_req    = req_q;
    assign task_id     = id_q;
    assign busy        = (state_q != S_IDLE);
    assign in_vblank   = vblank_q;
    assign frame_start = fs_q;
    assign frame_count = fcnt_q;
    assign timeout_err = terr_q;
    assign overrun     = over_q;
    assign overrun_cnt = ocnt_q;

endmodule

// File: tb/tb_vblank_task_scheduler.sv
// tb/tb_vblank_task_scheduler.sv - self-checking bench for vblank_task_scheduler
module tb_vblank_task_scheduler;

    logic        clk = 1'b0;
    logic        reset;
    logic        enable;
    logic [9:0]  hPos;
    logic [9:0]  vPos;
    logic        pause;
    logic [3:0]  task_en;
    logic [3:0]  task_ack;
    logic [3:0]  task_req;
    logic [1:0]  task_id;
    logic        busy;
    logic        in_vblank;
    logic        frame_start;
    logic [15:0] frame_count;
    logic [3:0]  timeout_err;
    logic        overrun;
    logic [7:0]  overrun_cnt;

    int total = 0;
    int bad   = 0;

    vblank_task_scheduler #(
        .N_TASKS(4), .TASK_W(2), .ACTIVE_V(480), .TIMEOUT_CYC(16)
    ) dut (
        .clk(clk), .reset(reset), .enable(enable), .hPos(hPos), .vPos(vPos),
        .pause(pause), .task_en(task_en), .task_ack(task_ack),
        .task_req(task_req), .task_id(task_id), .busy(busy),
        .in_vblank(in_vblank), .frame_start(frame_start),
        .frame_count(frame_count), .timeout_err(timeout_err),
        .overrun(overrun), .overrun_cnt(overrun_cnt)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic        en;
        logic [9:0]  h;
        logic [9:0]  v;
        logic [3:0]  ack;
        logic        fs;
        logic        vb;
        logic [3:0]  req;
        logic        bsy;
        logic [15:0] fc;
    } vec_t;

    vec_t tbl[$];

    int grants[$];
    int hi_cnt[4];
    int ack_dly[4];
    int gap_viol;
    int onehot_viol;
    int exp_fc;

    function automatic vec_t mk(input logic en, input int h, input int v, input logic [3:0] ack,
                                input logic fs, input logic vb, input logic [3:0] req,
                                input logic bsy, input int fc);
        vec_t r;
        r.en = en; r.h = 10'(h); r.v = 10'(v); r.ack = ack;
        r.fs = fs; r.vb = vb; r.req = req; r.bsy = bsy; r.fc = 16'(fc);
        return r;
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic frame_begin();
        vPos = 10'd480; hPos = 10'd0; enable = 1'b1;
        step();
        exp_fc++;
        hPos = 10'd1;
        chk("frame_start", frame_start, 1);
        chk("frame_count", frame_count, exp_fc);
    endtask

    task automatic end_frame();
        vPos = 10'd0; hPos = 10'd0;
        step();
        vPos = 10'd479;
        step();
    endtask

    task automatic clear_log();
        grants.delete();
        for (int i = 0; i < 4; i++) hi_cnt[i] = 0;
        gap_viol = 0;
        onehot_viol = 0;
    endtask

    // acts as the four engines and records grants until busy drops or budget expires
    task automatic run_frame(input int budget, output bit done);
        logic [3:0] prev;
        int cnt;
        int id;
        bit seen;
        prev = 4'd0; cnt = 0; id = 0; seen = 1'b0; done = 1'b0;
        for (int c = 0; c < budget; c++) begin
            step();
            if (busy) seen = 1'b1;
            if (task_req != 4'd0) begin
                if ($countones(task_req) != 1) onehot_viol++;
                if (prev != 4'd0 && prev != task_req) gap_viol++;
                for (int i = 0; i < 4; i++) if (task_req[i]) id = i;
                if (prev == 4'd0) begin
                    grants.push_back(id);
                    cnt = 0;
                end
                cnt++;
                hi_cnt[id]++;
                task_ack = (ack_dly[id] != 0 && cnt == ack_dly[id]) ? task_req : 4'd0;
            end else begin
                task_ack = 4'd0;
            end
            prev = task_req;
            if (seen && !busy) begin
                done = 1'b1;
                break;
            end
        end
        task_ack = 4'd0;
    endtask

    task automatic check_grants(input logic [3:0] mask);
        int expq[$];
        for (int i = 0; i < 4; i++) if (mask[i]) expq.push_back(i);
        chk("grant_count", grants.size(), expq.size());
        for (int i = 0; i < expq.size() && i < grants.size(); i++)
            chk("grant_order", grants[i], expq[i]);
        chk("gap_violations", gap_viol, 0);
        chk("onehot_violations", onehot_viol, 0);
    endtask

    initial begin
        bit   done;
        int   fc0;
        int   req_seen;

        exp_fc = 0;
        reset = 1'b0; enable = 1'b1; hPos = 10'd0; vPos = 10'd480;
        pause = 1'b0; task_en = 4'hF; task_ack = 4'hF;
        step(); step(); step();
        chk("rst_task_req", task_req, 0);
        chk("rst_task_id", task_id, 0);
        chk("rst_busy", busy, 0);
        chk("rst_in_vblank", in_vblank, 0);
        chk("rst_frame_start", frame_start, 0);
        chk("rst_frame_count", frame_count, 0);
        chk("rst_timeout_err", timeout_err, 0);
        chk("rst_overrun", overrun, 0);
        chk("rst_overrun_cnt", overrun_cnt, 0);

        reset = 1'b1; task_ack = 4'd0; task_en = 4'b0001; vPos = 10'd479;

        tbl.push_back(mk(1,   5, 479, 4'h0, 0, 0, 4'h0, 0, 0));
        tbl.push_back(mk(1,   0, 479, 4'h0, 0, 0, 4'h0, 0, 0));
        tbl.push_back(mk(0,   0, 480, 4'h0, 0, 1, 4'h0, 0, 0));
        tbl.push_back(mk(1,   0, 480, 4'h0, 1, 1, 4'h0, 0, 1));
        tbl.push_back(mk(1,   1, 480, 4'h1, 0, 1, 4'h0, 1, 1));
        tbl.push_back(mk(1,   2, 480, 4'h1, 0, 1, 4'h1, 1, 1));
        tbl.push_back(mk(1,   3, 480, 4'h0, 0, 1, 4'h1, 1, 1));
        tbl.push_back(mk(1,   4, 480, 4'h1, 0, 1, 4'h0, 1, 1));
        tbl.push_back(mk(1,   5, 480, 4'hF, 0, 1, 4'h0, 1, 1));
        tbl.push_back(mk(1,   6, 480, 4'h0, 0, 1, 4'h0, 1, 1));
        tbl.push_back(mk(1,   7, 480, 4'h0, 0, 1, 4'h0, 1, 1));
        tbl.push_back(mk(1,   8, 480, 4'h0, 0, 1, 4'h0, 1, 1));
        tbl.push_back(mk(1,   9, 480, 4'h0, 0, 1, 4'h0, 0, 1));

        for (int k = 0; k < tbl.size(); k++) begin
            enable = tbl[k].en; hPos = tbl[k].h; vPos = tbl[k].v; task_ack = tbl[k].ack;
            step();
            chk($sformatf("vec%0d_frame_start", k), frame_start, tbl[k].fs);
            chk($sformatf("vec%0d_in_vblank", k), in_vblank, tbl[k].vb);
            chk($sformatf("vec%0d_task_req", k), task_req, tbl[k].req);
            chk($sformatf("vec%0d_busy", k), busy, tbl[k].bsy);
            chk($sformatf("vec%0d_frame_count", k), frame_count, tbl[k].fc);
        end
        task_ack = 4'd0;
        exp_fc = 1;
        chk("vec_task_id", task_id, 0);

        // full frame, all tasks, ack after 5 clk
        end_frame();
        task_en = 4'hF;
        for (int i = 0; i < 4; i++) ack_dly[i] = 5;
        clear_log();
        frame_begin();
        run_frame(200, done);
        chk("full_done", done, 1);
        check_grants(4'hF);
        for (int i = 0; i < 4; i++) chk($sformatf("full_hi%0d", i), hi_cnt[i], 5);
        chk("full_busy", busy, 0);
        chk("full_frame_count", frame_count, exp_fc);
        chk("full_timeout_err", timeout_err, 0);
        chk("full_task_id", task_id, 3);
        chk("full_overrun_cnt", overrun_cnt, 0);

        // skip mask
        end_frame();
        task_en = 4'b1010;
        clear_log();
        frame_begin();
        run_frame(200, done);
        chk("skip_done", done, 1);
        check_grants(4'b1010);
        chk("skip_task_id", task_id, 3);

        // task 2 never acks
        end_frame();
        task_en = 4'hF;
        ack_dly[2] = 0;
        clear_log();
        frame_begin();
        run_frame(300, done);
        chk("tmo_done", done, 1);
        check_grants(4'hF);
        chk("tmo_hi2", hi_cnt[2], 16);
        chk("tmo_hi3", hi_cnt[3], 5);
        chk("tmo_timeout_err", timeout_err, 4'b0100);

        // ack in the same clk as expiry
        end_frame();
        task_en = 4'b1000;
        ack_dly[3] = 16;
        clear_log();
        frame_begin();
        run_frame(200, done);
        chk("race_done", done, 1);
        check_grants(4'b1000);
        chk("race_hi3", hi_cnt[3], 16);
        chk("race_timeout_err", timeout_err, 4'b0100);

        // overrun while task 1 holds off its ack
        end_frame();
        task_en = 4'hF;
        ack_dly[0] = 3; ack_dly[1] = 0; ack_dly[2] = 0; ack_dly[3] = 0;
        clear_log();
        frame_begin();
        run_frame(10, done);
        chk("ovr_not_done", done, 0);
        chk("ovr_req_before", task_req, 4'b0010);
        vPos = 10'd0;
        step();
        chk("ovr_pulse", overrun, 1);
        chk("ovr_cnt", overrun_cnt, 1);
        chk("ovr_task_req", task_req, 0);
        chk("ovr_busy", busy, 0);
        chk("ovr_in_vblank", in_vblank, 0);
        chk("ovr_timeout_err", timeout_err, 4'b0100);
        step();
        chk("ovr_pulse_once", overrun, 0);
        chk("ovr_cnt_hold", overrun_cnt, 1);
        vPos = 10'd479;
        step();
        for (int i = 0; i < 4; i++) ack_dly[i] = 5;
        clear_log();
        frame_begin();
        run_frame(200, done);
        chk("ovr_next_done", done, 1);
        check_grants(4'hF);
        chk("ovr_next_cnt", overrun_cnt, 1);

        // paused frames
        end_frame();
        pause = 1'b1;
        fc0 = exp_fc;
        req_seen = 0;
        for (int f = 0; f < 3; f++) begin
            frame_begin();
            for (int c = 0; c < 6; c++) begin
                step();
                if (task_req != 4'd0 || busy) req_seen++;
            end
            end_frame();
        end
        chk("pause_req_seen", req_seen, 0);
        chk("pause_frame_count", frame_count, fc0 + 3);
        chk("pause_overrun_cnt", overrun_cnt, 1);

        // reset in the middle of a handshake
        pause = 1'b0;
        task_en = 4'hF;
        frame_begin();
        step(); step();
        chk("mid_req_up", task_req, 4'b0001);
        reset = 1'b0;
        step();
        chk("mid_rst_req", task_req, 0);
        chk("mid_rst_busy", busy, 0);
        chk("mid_rst_frame_count", frame_count, 0);
        chk("mid_rst_timeout_err", timeout_err, 0);
        chk("mid_rst_overrun_cnt", overrun_cnt, 0);
        reset = 1'b1;
        step(); step();
        chk("mid_post_req", task_req, 0);
        chk("mid_post_busy", busy, 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
